// File: rtl/integer_alu_bus_slave.sv
// Memory-mapped integer/branch ALU on the shared 256-bit DataBus.
// Define IALU_MUL_EN to build the iterative shift-add multiplier (opcode 3).
module integer_alu_bus_slave #(
    parameter logic [15:0] BASE_ADDR = 16'h3000,
    parameter int unsigned MUL_W     = 128
) (
    input  logic         Clk,
    input  logic         Reset,
    inout  wire  [255:0] DataBus,
    input  logic [15:0]  address,
    input  logic         nRead,
    input  logic         nWrite
);

`ifdef IALU_MUL_EN
    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} aluState_t;
    localparam int CW = (MUL_W > 1) ? $clog2(MUL_W) : 1;
    localparam logic [CW-1:0] LAST = CW'(MUL_W - 1);
`else
    typedef enum logic [1:0] {IDLE, EXEC, DONE} aluState_t;
`endif

    aluState_t    state;
    logic [255:0] op1;
    logic [255:0] op2;
    logic [255:0] result;
    logic [255:0] aluOut;
    logic [255:0] readData;
    logic [3:0]   opc;
    logic         err;
    logic         done;
    logic         busy;

    logic         winHit;
    logic [11:0]  offs;
    logic         hitOp1;
    logic         hitOp2;
    logic         hitRes;
    logic         hitCmd;
    logic         hitStat;
    logic         wrEn;
    logic         rdEn;

    logic [3:0]   cmdOpc;
    logic         cmdTagOk;
    logic         opLegal;

`ifdef IALU_MUL_EN
    logic [2*MUL_W-1:0] acc;
    logic [2*MUL_W-1:0] mcand;
    logic [MUL_W-1:0]   mplier;
    logic [CW-1:0]      cnt;
`endif

    assign winHit  = address[15:12] == BASE_ADDR[15:12];
    assign offs    = address[11:0];
    assign hitOp1  = winHit && (offs == 12'h000);
    assign hitOp2  = winHit && (offs == 12'h001);
    assign hitRes  = winHit && (offs == 12'hD00);
    assign hitCmd  = winHit && (offs == 12'hE00);
    assign hitStat = winHit && (offs == 12'hF00);

    assign wrEn = !nWrite;
    // Never drive while a write is in progress to avoid contention.
    assign rdEn = !nRead && nWrite
               && (hitOp1 || hitOp2 || hitRes || hitStat);

    assign done = (state == DONE);
`ifdef IALU_MUL_EN
    assign busy = (state == EXEC) || (state == MUL);
`else
    assign busy = (state == EXEC);
`endif

    always_comb begin
        readData = '0;
        unique case (1'b1)
            hitOp1:  readData = op1;
            hitOp2:  readData = op2;
            hitRes:  readData = result;
            hitStat: readData = {254'b0, err, done};
            default: readData = '0;
        endcase
    end

    assign DataBus = rdEn ? readData : 'z;

    assign cmdOpc   = DataBus[11:8];
    assign cmdTagOk = DataBus[15:12] == BASE_ADDR[15:12];

    always_comb begin
        opLegal = 1'b0;
        if (cmdTagOk) begin
            case (cmdOpc)
                4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h7,
                4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD:
                    opLegal = 1'b1;
`ifdef IALU_MUL_EN
                4'h3:    opLegal = 1'b1;
`endif
                default: opLegal = 1'b0;
            endcase
        end
    end

    always_comb begin
        aluOut = '0;
        case (opc)
            4'h1: aluOut = op1 + op2;
            4'h2: aluOut = op1 - op2;
`ifdef IALU_MUL_EN
            4'h3: aluOut = 256'(acc);
`endif
            4'h4: aluOut = op1 & op2;
            4'h5: aluOut = op1 | op2;
            4'h6: aluOut = op1 ^ op2;
            4'h7: aluOut = op1 << op2[7:0];
            4'h8: aluOut = op1 >> op2[7:0];
            4'h9: aluOut = ~op1;
            4'hA: aluOut = {255'b0, op1 == op2};
            4'hB: aluOut = {255'b0, op1 != op2};
            4'hC: aluOut = {255'b0, $signed(op1) < $signed(op2)};
            4'hD: aluOut = {255'b0, $signed(op1) >= $signed(op2)};
            default: aluOut = '0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= IDLE;
            op1    <= '0;
            op2    <= '0;
            result <= '0;
            err    <= 1'b0;
            opc    <= '0;
`ifdef IALU_MUL_EN
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
`endif
        end else begin
            if (wrEn && !busy) begin
                if (hitOp1) op1 <= DataBus;
                if (hitOp2) op2 <= DataBus;
            end
            case (state)
                IDLE, DONE: begin
                    if (wrEn && hitCmd) begin
                        err <= 1'b0;
                        opc <= cmdOpc;
                        if (!opLegal) begin
                            result <= '0;
                            err    <= 1'b1;
                            state  <= DONE;
                        end
`ifdef IALU_MUL_EN
                        else if (cmdOpc == 4'h3) begin
                            acc    <= '0;
                            mcand  <= {{MUL_W{1'b0}}, op1[MUL_W-1:0]};
                            mplier <= op2[MUL_W-1:0];
                            cnt    <= '0;
                            state  <= MUL;
                        end
`endif
                        else begin
                            state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    result <= aluOut;
                    state  <= DONE;
                end
`ifdef IALU_MUL_EN
                // Last bit hands over to EXEC, which registers the product.
                MUL: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) state <= EXEC;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_integer_alu_bus_slave.sv
// Directed bench for integer_alu_bus_slave: vector table plus multiply,
// illegal-opcode and reset sequences; follows IALU_MUL_EN like the RTL.
module tb_integer_alu_bus_slave;

    localparam logic [15:0] A_OP1  = 16'h3000;
    localparam logic [15:0] A_OP2  = 16'h3001;
    localparam logic [15:0] A_RES  = 16'h3D00;
    localparam logic [15:0] A_CMD  = 16'h3E00;
    localparam logic [15:0] A_STAT = 16'h3F00;

    localparam logic [255:0] ALL1 = {256{1'b1}};
    localparam logic [255:0] TOP  = {1'b1, 255'b0};

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    wire  [255:0] DataBus;
    logic [15:0]  address = '0;
    logic         nRead = 1'b1;
    logic         nWrite = 1'b1;
    logic [255:0] busDrv = '0;
    logic         busOe = 1'b0;

    int nAssert = 0;
    int nFail = 0;

    assign DataBus = busOe ? busDrv : 'z;

    always #5 Clk = ~Clk;

    integer_alu_bus_slave dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .DataBus (DataBus),
        .address (address),
        .nRead   (nRead),
        .nWrite  (nWrite)
    );

    typedef struct {
        string        name;
        logic [255:0] op1;
        logic [255:0] op2;
        logic [15:0]  cmd;
        logic [255:0] immStat;
        logic [255:0] finStat;
        logic [255:0] res;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string n, logic [255:0] a, logic [255:0] b,
                                logic [15:0] c, logic [255:0] si,
                                logic [255:0] sf, logic [255:0] r);
        vec_t v;
        v.name = n; v.op1 = a; v.op2 = b; v.cmd = c;
        v.immStat = si; v.finStat = sf; v.res = r;
        return v;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [255:0] d);
        address = a;
        busDrv  = d;
        busOe   = 1'b1;
        nWrite  = 1'b0;
        @(posedge Clk);
        #1;
        nWrite  = 1'b1;
        busOe   = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [255:0] d);
        address = a;
        nRead   = 1'b0;
        #1;
        d       = DataBus;
        nRead   = 1'b1;
    endtask

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        nAssert++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chkRd(input string nm, input logic [15:0] a,
                         input logic [255:0] exp);
        logic [255:0] v;
        rd(a, v);
        chk(nm, v, exp);
    endtask

    // Undriven bus: 'z in a 4-state simulator, all-zero in a 2-state one.
    task automatic chkUndriven(input string nm);
        logic [255:0] v;
        #1;
        v = DataBus;
        nAssert++;
        if (!((v === {256{1'bz}}) || (v === '0))) begin
            nFail++;
            $display("FAIL %s: bus driven with %h, expected no driver", nm, v);
        end
    endtask

    initial begin
        logic [255:0] v;
        int           bad;

        vecs.push_back(mk("add",      256'd5,     256'd7,     16'h3100, 0, 1, 256'd12));
        vecs.push_back(mk("add wrap", ALL1,       256'd1,     16'h3100, 0, 1, 256'd0));
        vecs.push_back(mk("sub",      256'd0,     256'd1,     16'h3200, 0, 1, ALL1));
        vecs.push_back(mk("and",      256'hF0F0,  256'hFF00,  16'h3400, 0, 1, 256'hF000));
        vecs.push_back(mk("or",       256'hF0F0,  256'hFF00,  16'h3500, 0, 1, 256'hFFF0));
        vecs.push_back(mk("xor",      256'hF0F0,  256'hFF00,  16'h3600, 0, 1, 256'h0FF0));
        vecs.push_back(mk("shl 255",  256'd1,     256'hFF,    16'h3700, 0, 1, TOP));
        vecs.push_back(mk("shl 8bit", 256'd1,     256'h104,   16'h3700, 0, 1, 256'd16));
        vecs.push_back(mk("shl 0",    256'hABCD,  256'd0,     16'h3700, 0, 1, 256'hABCD));
        vecs.push_back(mk("shr 255",  TOP,        256'hFF,    16'h3800, 0, 1, 256'd1));
        vecs.push_back(mk("shr log",  TOP,        256'd4,     16'h3800, 0, 1, 256'd1 << 251));
        vecs.push_back(mk("not",      256'd0,     256'd3,     16'h3900, 0, 1, ALL1));
        vecs.push_back(mk("eq t",     256'd5,     256'd5,     16'h3A00, 0, 1, 256'd1));
        vecs.push_back(mk("ne f",     256'd5,     256'd5,     16'h3B00, 0, 1, 256'd0));
        vecs.push_back(mk("ne t",     256'd5,     256'd6,     16'h3B00, 0, 1, 256'd1));
        vecs.push_back(mk("lt -1<0",  ALL1,       256'd0,     16'h3C00, 0, 1, 256'd1));
        vecs.push_back(mk("lt 0<-1",  256'd0,     ALL1,       16'h3C00, 0, 1, 256'd0));
        vecs.push_back(mk("lt 3<5",   256'd3,     256'd5,     16'h3C00, 0, 1, 256'd1));
        vecs.push_back(mk("ge -1>=0", ALL1,       256'd0,     16'h3D00, 0, 1, 256'd0));
        vecs.push_back(mk("ge 5>=5",  256'd5,     256'd5,     16'h3D00, 0, 1, 256'd1));
        vecs.push_back(mk("ill F",    256'd5,     256'd5,     16'h3F00, 3, 3, 256'd0));
        vecs.push_back(mk("eq clr",   256'd7,     256'd7,     16'h3A00, 0, 1, 256'd1));
        vecs.push_back(mk("ill tag",  256'd7,     256'd7,     16'h2100, 3, 3, 256'd0));
        vecs.push_back(mk("eq clr2",  256'd9,     256'd9,     16'h3A00, 0, 1, 256'd1));
        vecs.push_back(mk("ill 0",    256'd1,     256'd1,     16'h3000, 3, 3, 256'd0));
        vecs.push_back(mk("ill E",    256'd1,     256'd1,     16'h3E00, 3, 3, 256'd0));

        tick();
        tick();
        Reset = 1'b0;

        chkRd("reset status", A_STAT, 256'd0);
        chkRd("reset result", A_RES, 256'd0);
        chkRd("reset op1", A_OP1, 256'd0);

        wr(A_OP1, 256'd5);
        wr(A_OP2, 256'd9);
        chkRd("op1 readback", A_OP1, 256'd5);
        chkRd("op2 readback", A_OP2, 256'd9);

        address = A_OP1;
        chkUndriven("no strobe");
        address = A_OP1; nRead = 1'b0; nWrite = 1'b0;
        chkUndriven("read during write");
        nRead = 1'b1; nWrite = 1'b1;
        address = 16'h3005; nRead = 1'b0;
        chkUndriven("unmapped window");
        address = 16'h4000;
        chkUndriven("outside window");
        nRead = 1'b1;

        foreach (vecs[i]) begin
            wr(A_OP1, vecs[i].op1);
            wr(A_OP2, vecs[i].op2);
            wr(A_CMD, {240'b0, vecs[i].cmd});
            chkRd({vecs[i].name, " stat0"}, A_STAT, vecs[i].immStat);
            tick();
            chkRd({vecs[i].name, " stat1"}, A_STAT, vecs[i].finStat);
            chkRd({vecs[i].name, " result"}, A_RES, vecs[i].res);
        end

        chkRd("result holds", A_RES, 256'd0);
        chkRd("status holds", A_STAT, 256'd3);

        wr(A_OP1, {128'b0, {128{1'b1}}});
        wr(A_OP2, {128'b0, {128{1'b1}}});
        wr(A_CMD, 256'h3300);
`ifdef IALU_MUL_EN
        bad = 0;
        rd(A_STAT, v);
        if (v !== 256'd0) bad++;
        for (int e = 1; e <= 129; e++) begin
            if (e == 40)      wr(A_CMD, 256'h3100);
            else if (e == 50) wr(A_OP1, 256'd0);
            else if (e == 60) wr(A_OP2, 256'd0);
            else              tick();
            rd(A_STAT, v);
            if (e < 129 && v !== 256'd0) bad++;
            if (e == 129) chk("mul done", v, 256'd1);
        end
        chk("mul busy polls", 256'(bad), 256'd0);
        chkRd("mul result", A_RES,
              256'd1 - (256'd1 << 129));
        chkRd("mul op1 kept", A_OP1, {128'b0, {128{1'b1}}});
        chkRd("mul op2 kept", A_OP2, {128'b0, {128{1'b1}}});
        chkRd("mul read keeps done", A_STAT, 256'd1);
`else
        chkRd("mul off status", A_STAT, 256'd3);
        chkRd("mul off result", A_RES, 256'd0);
`endif

        wr(A_OP1, 256'd6);
        wr(A_OP2, 256'd3);
        wr(A_CMD, 256'h3300);
        for (int e = 1; e < 60; e++) tick();
`ifdef IALU_MUL_EN
        chkRd("mul busy e59", A_STAT, 256'd0);
`else
        chkRd("mul off e59", A_STAT, 256'd3);
`endif
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chkRd("abort status", A_STAT, 256'd0);
        chkRd("abort result", A_RES, 256'd0);

        wr(A_OP1, 256'd1);
        wr(A_OP2, 256'd1);
        wr(A_CMD, 256'h3100);
        tick();
        chkRd("add after rst st", A_STAT, 256'd1);
        chkRd("add after rst", A_RES, 256'd2);

        Reset = 1'b1;
        wr(A_OP1, 256'h55);
        Reset = 1'b0;
        chkRd("reset beats write", A_OP1, 256'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nAssert, nFail);
        $finish;
    end

endmodule
